// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over row-triplet column samples.
// Column window -> products -> sum -> normalise/clamp, with row and frame end flags.
module conv3x3_stream #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned COEF_W = 4,
   parameter int unsigned IMG_W  = 640,
   parameter int unsigned IMG_H  = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ready,
   input  logic                  valid_i,
   input  logic [DATA_W-1:0]     fifo1_data_i,
   input  logic [DATA_W-1:0]     fifo2_data_i,
   input  logic [DATA_W-1:0]     fifo3_data_i,
   input  logic [9*COEF_W-1:0]   kernel_i,
   input  logic [3:0]            shift_i,
   input  logic                  mode_i,
   output logic [DATA_W-1:0]     data_o,
   output logic                  valid_o,
   output logic                  done,
   output logic                  done_o,
   output logic                  busy_o
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned PW = DATA_W + 1 + COEF_W;
   localparam int unsigned SW = DATA_W + COEF_W + 5;
   localparam logic [SW-1:0] PIX_MAX = {{(SW-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state;
   logic [CW-1:0]           col;
   logic [RW-1:0]           row;
   logic [9*COEF_W-1:0]     kern_q;
   logic [3:0]              shift_q;
   logic                    mode_q;
   logic [DATA_W-1:0]       win [3][3];
   logic                    w_valid, w_row_end, w_frame_end;
   logic                    p_valid, p_row_end, p_frame_end;
   logic                    s_valid, s_row_end, s_frame_end;
   logic signed [COEF_W-1:0] coef_c [9];
   logic signed [PW-1:0]    prod [9];
   logic signed [SW-1:0]    sum_c, sum_q;
   logic signed [SW-1:0]    ash_c;
   logic [SW-1:0]           mag_c, lsh_c;
   logic [DATA_W-1:0]       res_c;
   logic                    accept_c, col_last_c, row_last_c;

   assign accept_c   = (state == RUN) && valid_i;
   assign col_last_c = (col == CW'(IMG_W - 1));
   assign row_last_c = (row == RW'(IMG_H - 3));

   // Control FSM, counters and column window; win[r][0] holds the oldest column.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy_o      <= 1'b0;
         col         <= '0;
         row         <= '0;
         kern_q      <= '0;
         shift_q     <= '0;
         mode_q      <= 1'b0;
         w_valid     <= 1'b0;
         w_row_end   <= 1'b0;
         w_frame_end <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else begin
         w_valid     <= accept_c && (col >= CW'(2));
         w_row_end   <= accept_c && col_last_c;
         w_frame_end <= accept_c && col_last_c && row_last_c;
         case (state)
            IDLE: begin
               if (ready) begin
                  state   <= RUN;
                  busy_o  <= 1'b1;
                  kern_q  <= kernel_i;
                  shift_q <= shift_i;
                  mode_q  <= mode_i;
                  col     <= '0;
                  row     <= '0;
               end
            end
            RUN: begin
               if (valid_i) begin
                  for (int r = 0; r < 3; r++) begin
                     win[r][0] <= win[r][1];
                     win[r][1] <= win[r][2];
                  end
                  win[0][2] <= fifo1_data_i;
                  win[1][2] <= fifo2_data_i;
                  win[2][2] <= fifo3_data_i;
                  if (col_last_c) begin
                     col <= '0;
                     row <= row + RW'(1);
                     if (row_last_c) state <= DRAIN;
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (done_o) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++)
         coef_c[i] = $signed(kern_q[i*COEF_W +: COEF_W]);
   end

   // Datapath registers; qualified by the valid pipeline, so no reset needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 9; i++)
         prod[i] <= PW'($signed({1'b0, win[i/3][i%3]})) * PW'(coef_c[i]);
      sum_q <= sum_c;
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < 9; i++)
         sum_c = sum_c + SW'(prod[i]);
   end

   always_comb begin
      ash_c = sum_q >>> shift_q;
      mag_c = sum_q[SW-1] ? $unsigned(-sum_q) : $unsigned(sum_q);
      lsh_c = mag_c >> shift_q;
      res_c = '0;
      if (!mode_q) begin
         if (ash_c[SW-1])                  res_c = '0;
         else if ($unsigned(ash_c) > PIX_MAX) res_c = '1;
         else                              res_c = ash_c[DATA_W-1:0];
      end else begin
         if (lsh_c > PIX_MAX) res_c = '1;
         else                 res_c = lsh_c[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_valid     <= 1'b0;
         p_row_end   <= 1'b0;
         p_frame_end <= 1'b0;
         s_valid     <= 1'b0;
         s_row_end   <= 1'b0;
         s_frame_end <= 1'b0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         done        <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         p_valid     <= w_valid;
         p_row_end   <= w_row_end;
         p_frame_end <= w_frame_end;
         s_valid     <= p_valid;
         s_row_end   <= p_row_end;
         s_frame_end <= p_frame_end;
         valid_o     <= s_valid;
         done        <= s_valid && s_row_end;
         done_o      <= s_valid && s_frame_end;
         if (s_valid) data_o <= res_c;
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream: frame-level reference model plus literal expectations.
module tb_conv3x3_stream;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int ROWS = H - 2;

   logic        clk = 1'b0;
   logic        rst, ready, valid_i, mode_i;
   logic [7:0]  f1, f2, f3;
   logic [35:0] kernel_i;
   logic [3:0]  shift_i;
   logic [7:0]  data_o;
   logic        valid_o, done, done_o, busy_o;

   always #5 clk = ~clk;

   conv3x3_stream #(.DATA_W(8), .COEF_W(4), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .ready(ready), .valid_i(valid_i),
      .fifo1_data_i(f1), .fifo2_data_i(f2), .fifo3_data_i(f3),
      .kernel_i(kernel_i), .shift_i(shift_i), .mode_i(mode_i),
      .data_o(data_o), .valid_o(valid_o), .done(done), .done_o(done_o), .busy_o(busy_o)
   );

   typedef struct {int data; bit row_end; bit frame_end;} exp_t;
   exp_t expq[$];
   int   got_q[$];
   int   t_q[$];
   int   checks = 0, errors = 0, cyc = 0;
   int   out_cnt, done_cnt, doneo_cnt, acc3, first_t;
   bit   chk_en = 1'b0, prev_done_o = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int coef(input logic [35:0] k, input int i);
      logic [3:0] v;
      v = k[i*4 +: 4];
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   // Reference: floor division by 2^sh, or magnitude scaled down, then clamp to 0..255.
   function automatic int norm(input int s, input int sh, input bit m);
      int v;
      if (!m) begin
         v = s >>> sh;
         if (v < 0) v = 0;
      end else begin
         v = (s < 0 ? -s : s) >> sh;
      end
      if (v > 255) v = 255;
      return v;
   endfunction

   // Compare process, one sample per cycle just after the active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (chk_en) begin
            if (prev_done_o) chk("busy_after_done_o", int'(busy_o), 0);
            prev_done_o = done_o;
            if (done)   done_cnt++;
            if (done_o) doneo_cnt++;
            if (valid_o) begin
               out_cnt++;
               got_q.push_back(int'(data_o));
               t_q.push_back(cyc);
               if (first_t < 0) first_t = cyc;
               if (expq.size() == 0) begin
                  chk("unexpected_valid_o", 1, 0);
               end else begin
                  e = expq.pop_front();
                  chk("data_o", int'(data_o), e.data);
                  chk("done", int'(done), int'(e.row_end));
                  chk("done_o", int'(done_o), int'(e.frame_end));
               end
            end else begin
               chk("stray_done_flags", int'({done, done_o}), 0);
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && busy_o !== 1'b0; i++) @(negedge clk);
      chk(name, int'(busy_o), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid_i = 1'b0; ready = 1'b0;
      @(posedge clk);
      #2;
      expq.delete();
      chk("rst_data_o", int'(data_o), 0);
      chk("rst_valid_o", int'(valid_o), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_done_o", int'(done_o), 0);
      chk("rst_busy_o", int'(busy_o), 0);
      @(negedge clk);
      rst = 1'b0;
      out_cnt = 0; doneo_cnt = 0;
      repeat (8) @(negedge clk);
      chk("no_output_after_rst", out_cnt, 0);
      chk("no_done_o_after_rst", doneo_cnt, 0);
   endtask

   // pat: 0 random, 1 ramp, 2 constant; stall: 0 none, 1 random, 2 two cycles before row0 col4.
   task automatic run_frame(input logic [35:0] kern, input int sh, input bit md, input int pat,
                            input int cval, input int stall, input bit hold, input int abort_at);
      int img [3][W];
      int k [9];
      int n, s, ns, kk;
      for (int i = 0; i < 9; i++) k[i] = coef(kern, i);
      wait_idle("idle_before_start");
      out_cnt = 0; done_cnt = 0; doneo_cnt = 0; first_t = -1; acc3 = -1; n = 0;
      got_q.delete(); t_q.delete();
      @(negedge clk);
      ready = 1'b1; kernel_i = kern; shift_i = 4'(sh); mode_i = md;
      valid_i = 1'b1; f1 = 8'($urandom); f2 = 8'($urandom); f3 = 8'($urandom);
      for (int t = 0; t < ROWS; t++) begin
         for (int c = 0; c < W; c++) begin
            for (int r = 0; r < 3; r++) begin
               kk = t * W + c;
               case (pat)
                  1:       img[r][c] = (kk + (r == 0 ? 0 : r + 2)) & 255;
                  2:       img[r][c] = cval;
                  default: img[r][c] = int'($urandom_range(0, 255));
               endcase
            end
         end
         for (int c = 2; c < W; c++) begin
            s = 0;
            for (int r = 0; r < 3; r++)
               for (int cc = 0; cc < 3; cc++)
                  s += k[r*3+cc] * img[r][c-2+cc];
            expq.push_back('{norm(s, sh, md), c == W - 1, (c == W - 1) && (t == ROWS - 1)});
         end
         for (int c = 0; c < W; c++) begin
            if (n == abort_at) begin
               do_reset();
               return;
            end
            if (stall == 1)      ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            else if (stall == 2) ns = (t == 0 && c == 4) ? 2 : 0;
            else                 ns = 0;
            repeat (ns) begin
               @(negedge clk);
               ready = hold; valid_i = 1'b0;
               f1 = 8'($urandom); f2 = 8'($urandom); f3 = 8'($urandom);
            end
            @(negedge clk);
            ready = hold;
            kernel_i = 36'({$urandom, $urandom}); shift_i = 4'($urandom); mode_i = 1'($urandom);
            valid_i = 1'b1;
            f1 = 8'(img[0][c]); f2 = 8'(img[1][c]); f3 = 8'(img[2][c]);
            n++;
            if (n == 3) acc3 = cyc + 1;
         end
      end
      repeat (3) begin
         @(negedge clk);
         ready = 1'b0; valid_i = 1'b1;
         f1 = 8'($urandom); f2 = 8'($urandom); f3 = 8'($urandom);
      end
      @(negedge clk);
      valid_i = 1'b0;
      wait_idle("drain_to_idle");
      chk("expected_left_over", expq.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ref_q[$];
      int bad;
      rst = 1'b1; ready = 1'b0; valid_i = 1'b0; mode_i = 1'b0;
      f1 = '0; f2 = '0; f3 = '0; kernel_i = '0; shift_i = '0;
      repeat (3) @(negedge clk);
      chk("init_data_o", int'(data_o), 0);
      chk("init_valid_o", int'(valid_o), 0);
      chk("init_busy_o", int'(busy_o), 0);
      chk("init_done_o", int'(done_o), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Box filter over a flat image: 72 >> 3 everywhere, with framing counts.
      run_frame(36'h111111111, 3, 1'b0, 2, 8, 0, 1'b0, -1);
      chk("box_out_count", out_cnt, 12);
      chk("box_done_count", done_cnt, 2);
      chk("box_done_o_count", doneo_cnt, 1);
      chk("first_valid_latency", first_t - acc3, 3);
      bad = 0;
      foreach (got_q[i]) if (got_q[i] != 9) bad++;
      chk("box_all_nine", bad, 0);

      run_frame(36'h777777777, 0, 1'b0, 2, 255, 0, 1'b0, -1);
      chk("sat_first", (got_q.size() > 0) ? got_q[0] : -1, 255);
      run_frame(36'h000080000, 0, 1'b0, 2, 10, 0, 1'b0, -1);
      chk("neg_clamp_first", (got_q.size() > 0) ? got_q[0] : -1, 0);
      run_frame(36'h000080000, 0, 1'b1, 2, 10, 0, 1'b0, -1);
      chk("abs_first", (got_q.size() > 0) ? got_q[0] : -1, 80);

      // Ramp with and without a two-cycle stall must give the same pixels.
      run_frame(36'h1F2E3D4C5, 2, 1'b1, 1, 0, 0, 1'b0, -1);
      ref_q = got_q;
      run_frame(36'h1F2E3D4C5, 2, 1'b1, 1, 0, 2, 1'b1, -1);
      bad = (got_q.size() == ref_q.size()) ? 0 : 1;
      foreach (ref_q[i]) if (i < got_q.size() && got_q[i] != ref_q[i]) bad++;
      chk("stall_same_sequence", bad, 0);
      chk("stall_gap", (t_q.size() > 2) ? t_q[2] - t_q[1] : -1, 3);

      // Reset partway into output row 1, then a clean frame.
      run_frame(36'h111111111, 3, 1'b0, 2, 8, 0, 1'b0, 10);
      run_frame(36'h111111111, 3, 1'b0, 2, 8, 0, 1'b0, -1);
      chk("post_rst_out_count", out_cnt, 12);
      chk("post_rst_done_count", done_cnt, 2);
      chk("post_rst_done_o_count", doneo_cnt, 1);

      for (int f = 0; f < 6; f++)
         run_frame(36'({$urandom, $urandom}), int'($urandom_range(0, 5)), 1'($urandom),
                   0, 0, 1, 1'b0, -1);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 Parameter DATA_W, default 8: pixel width, unsigned.
REQ-002 Parameter COEF_W, default 4: kernel coefficient width, two's complement.
REQ-003 Parameter IMG_W, default 640: pixels per input row (minimum 3).
REQ-004 Parameter IMG_H, default 480: input rows per frame (minimum 3); frame yields IMG_H-2 output rows.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ready  in  1  frame start request, sampled in IDLE only.
REQ-008 valid_i  in  1  row-triplet sample valid.
REQ-009 fifo1_data_i, fifo2_data_i, fifo3_data_i  in  DATA_W each  top, middle, bottom row pixels of one column.
REQ-010 kernel_i  in  9*COEF_W  coefficients; index r*3+c at bits [(r*3+c)*COEF_W +: COEF_W]; r=0 fifo1 row, c=0 oldest column.
REQ-011 shift_i  in  4  right-shift normalisation amount.
REQ-012 mode_i  in  1  0 = clamped signed result, 1 = absolute-value result.
REQ-013 data_o  out  DATA_W  convolution result.
REQ-014 valid_o  out  1  data_o valid, one-cycle qualifier per output pixel.
REQ-015 done  out  1  one-cycle pulse with the last output pixel of each output row.
REQ-016 done_o  out  1  one-cycle pulse with the last output pixel of the frame.
REQ-017 busy_o  out  1  high in RUN and DRAIN.

Function
REQ-018 FSM states IDLE, RUN, DRAIN; IDLE->RUN on ready=1, latching kernel_i, shift_i, mode_i; later changes ignored until next IDLE.
REQ-019 In IDLE, valid_i ignored; in RUN, each cycle with valid_i=1 accepts one column into a 3-column shift window and advances column counter.
REQ-020 valid_i=0 in RUN: window and counters hold; pipeline advances a bubble (valid_o=0 for that slot).
REQ-021 Output produced for each accepted column with column index >= 2, giving IMG_W-2 outputs per row.
REQ-022 Column counter wraps IMG_W-1 -> 0 and increments row counter; window treated empty, so first two columns of each row produce no output.
REQ-023 Pipeline: window register (edge N, accept) -> 9 signed products (N+1) -> adder tree sum (N+2) -> normalise/clamp register (N+3); valid_o high in cycle after edge N+3.
REQ-024 Products: pixel zero-extended to DATA_W+1 bits times signed coefficient; sum width DATA_W+COEF_W+5 bits, no overflow possible.
REQ-025 mode 0: sum arithmetic-shifted right by shift_i (truncate toward minus infinity), then clamped to [0, 2^DATA_W-1].
REQ-026 mode 1: absolute value of sum, logical shift right by shift_i, clamped to 2^DATA_W-1.
REQ-027 Acceptance of last column of row IMG_H-3 (0-based output row count) moves RUN->DRAIN; further valid_i ignored.
REQ-028 DRAIN -> IDLE in cycle after done_o pulse; done and done_o both asserted on the frame's final output.
REQ-029 ready deasserted mid-frame has no effect; ready held high in IDLE starts next frame immediately.

Reset
REQ-030 rst=1 at any rising edge: state IDLE, counters, window and pipeline valids cleared; data_o=0, valid_o=0, done=0, done_o=0, busy_o=0 from next cycle.
REQ-031 rst mid-frame discards in-flight results; no valid_o, done or done_o emitted after reset until a new frame starts.

Verification
REQ-032 Box: IMG_W=8, IMG_H=4, kernel all 1, shift 3, mode 0, all inputs 8 -> every data_o = 9 (72>>3).
REQ-033 Saturation/clamp: inputs 255, kernel all 7, shift 0 -> data_o=255; centre coef -8 others 0, input 10: mode 0 -> 0, mode 1 -> 80.
REQ-034 Framing: IMG_W=8, IMG_H=4, continuous valid_i -> first valid_o 3 cycles after 3rd accept, 6 outputs per row, done on 6th and 12th, done_o on 12th only, busy_o low next cycle.
REQ-035 Stall: ramp input (fifo1=k, fifo2=k+3, fifo3=k+4), valid_i low 2 cycles mid-row -> identical data_o sequence versus unstalled run, 2-cycle gap in valid_o.
REQ-036 Reset mid-frame at output row 1 -> outputs 0 next cycle, no done_o; fresh frame afterward matches REQ-034 counts.
